skinny_sbox_layer_ctrl: RTL and testbench



---
 rtl/skinny_masked_pkg.sv | 19 +
 rtl/sbox_tag_pipe.sv | 24 ++
 rtl/skinny_sbox_layer_ctrl.sv | 88 ++++++++
 tb/tb_skinny_sbox_layer_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/skinny_masked_pkg.sv
// rtl/skinny_masked_pkg.sv - shared constants and types for the masked Skinny-64 S-box layer
package skinny_masked_pkg;
  localparam int SHARES   = 4;
  localparam int NIBBLES  = 16;
  localparam int SBOX_LAT = 2;
  localparam int FRESH_W  = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } tag_t;
endpackage

// File: rtl/sbox_tag_pipe.sv
// rtl/sbox_tag_pipe.sv - tag shift register running in lockstep with the S-box pipeline registers
module sbox_tag_pipe
  import skinny_masked_pkg::*;
#(
  parameter int LAT = SBOX_LAT
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t pipe [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[LAT-1];
endmodule

// File: rtl/skinny_sbox_layer_ctrl.sv
// rtl/skinny_sbox_layer_ctrl.sv - feeds one shared 64-bit state through the masked S-box nibble by nibble
module skinny_sbox_layer_ctrl
  import skinny_masked_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SHARES*64-1:0]    in_state,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SHARES*64-1:0]    out_state,
  output logic [SHARES*4-1:0]     sbox_x,
  output logic [FRESH_W-1:0]      sbox_fresh,
  input  logic [SHARES*4-1:0]     sbox_y,
  output logic                    rnd_req,
  input  logic [FRESH_W-1:0]      rnd_in,
  input  logic                    rnd_valid
);
  state_e                 state;
  logic [3:0]             feed_cnt;
  logic [4:0]             cap_cnt;
  logic [SHARES*64-1:0]   in_reg;
  logic [SHARES*64-1:0]   out_reg;
  tag_t                   tag_push;
  tag_t                   tag_out;
  logic                   feeding;
  logic                   capture;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_state = out_reg;
  assign rnd_req   = (state == FEED);
  assign feeding   = (state == FEED) && rnd_valid;
  assign capture   = ((state == FEED) || (state == DRAIN)) && tag_out.valid;

  // Cycles without randomness still clock the S-box, so they carry an all-zero bubble.
  always_comb begin
    sbox_x     = '0;
    sbox_fresh = '0;
    tag_push   = '0;
    if (feeding) begin
      for (int s = 0; s < SHARES; s++)
        sbox_x[s*4 +: 4] = in_reg[s*64 + int'(feed_cnt)*4 +: 4];
      sbox_fresh     = rnd_in;
      tag_push.valid = 1'b1;
      tag_push.idx   = feed_cnt;
    end
  end

  sbox_tag_pipe #(.LAT(SBOX_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_push),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      feed_cnt <= '0;
      cap_cnt  <= '0;
      in_reg   <= '0;
      out_reg  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_reg   <= in_state;
          feed_cnt <= '0;
          cap_cnt  <= '0;
          state    <= FEED;
        end
        FEED: if (rnd_valid) begin
          feed_cnt <= feed_cnt + 4'd1;
          if (feed_cnt == 4'(NIBBLES-1)) state <= DRAIN;
        end
        DRAIN: if (cap_cnt == 5'(NIBBLES)) state <= DONE;
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (capture) begin
        for (int s = 0; s < SHARES; s++)
          out_reg[s*64 + int'(tag_out.idx)*4 +: 4] <= sbox_y[s*4 +: 4];
        cap_cnt <= cap_cnt + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_skinny_sbox_layer_ctrl.sv
// tb/tb_skinny_sbox_layer_ctrl.sv - directed bench with a behavioural 2-stage masked S-box beside the DUT
module tb_skinny_sbox_layer_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_state;
  logic [15:0]  sbox_x;
  logic [47:0]  sbox_fresh;
  logic [15:0]  sbox_y;
  logic         rnd_req;
  logic [47:0]  rnd_in;
  logic         rnd_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  skinny_sbox_layer_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_state   (in_state),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .sbox_x     (sbox_x),
    .sbox_fresh (sbox_fresh),
    .sbox_y     (sbox_y),
    .rnd_req    (rnd_req),
    .rnd_in     (rnd_in),
    .rnd_valid  (rnd_valid)
  );

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h6; 4'h2: return 4'h9; 4'h3: return 4'h0;
      4'h4: return 4'h1; 4'h5: return 4'hA; 4'h6: return 4'h2; 4'h7: return 4'hB;
      4'h8: return 4'h3; 4'h9: return 4'h8; 4'hA: return 4'h5; 4'hB: return 4'hD;
      4'hC: return 4'h4; 4'hD: return 4'hE; 4'hE: return 4'h7; default: return 4'hF;
    endcase
  endfunction

  function automatic logic [63:0] layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[i*4 +: 4] = sbox4(x[i*4 +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] unshare(input logic [255:0] st);
    return st[63:0] ^ st[127:64] ^ st[191:128] ^ st[255:192];
  endfunction

  function automatic logic [255:0] rand_state();
    logic [255:0] r;
    for (int s = 0; s < 8; s++) r[s*32 +: 32] = $urandom();
    return r;
  endfunction

  // Share 0 carries the masked result; shares 1-3 are fresh nibbles, so the XOR is S(x).
  function automatic logic [15:0] mask_y(input logic [15:0] x, input logic [47:0] f);
    logic [3:0] y;
    y = sbox4(x[3:0] ^ x[7:4] ^ x[11:8] ^ x[15:12]);
    return {f[11:8], f[7:4], f[3:0], y ^ f[3:0] ^ f[7:4] ^ f[11:8]};
  endfunction

  logic [15:0] sb_p1, sb_p2;
  always_ff @(posedge clk) begin
    sb_p1 <= mask_y(sbox_x, sbox_fresh);
    sb_p2 <= sb_p1;
  end
  assign sbox_y = sb_p2;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake edge is T; step k ends at edge T+k. Returns k of first out_valid (or -1).
  task automatic run_op(input logic [255:0] st, input int b0, input int b1, input int b2,
                        input bit hold, input logic [255:0] other, input int abort_at,
                        output int lat, output int used);
    in_state = st;
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (hold) in_state = other;
    else in_valid = 1'b0;
    lat  = -1;
    used = 0;
    for (int k = 1; k <= 60; k++) begin
      rnd_valid = !(k == b0 || k == b1 || k == b2);
      rnd_in    = {16'($urandom()), $urandom()};
      if (k == abort_at) rst = 1'b1;
      #1;
      if (rnd_req && rnd_valid) begin
        used++;
        chk("fresh_forward", 256'(sbox_fresh), 256'(rnd_in));
      end else if (rnd_req) begin
        chk("bubble_zero", 256'({sbox_x, sbox_fresh}), 256'(0));
      end
      @(posedge clk); #1;
      if (abort_at > 0) begin
        if (k == abort_at) begin
          rst = 1'b0;
          chk("abort_in_ready", 256'(in_ready), 256'(1));
          chk("abort_out_state", out_state, 256'(0));
          chk("abort_rnd_req", 256'(rnd_req), 256'(0));
          lat = k;
          break;
        end
        chk("abort_no_valid", 256'(out_valid), 256'(0));
      end else if (out_valid) begin
        lat = k;
        break;
      end
    end
    in_valid  = 1'b0;
    rnd_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("pop_in_ready", 256'(in_ready), 256'(1));
    chk("pop_out_valid", 256'(out_valid), 256'(0));
  endtask

  initial begin
    logic [255:0] st, st2, held;
    int lat, used;

    rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
    rnd_in = '0; rnd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_state", out_state, 256'(0));
    chk("rst_sbox", 256'({sbox_x, sbox_fresh}), 256'(0));
    chk("rst_rnd_req", 256'(rnd_req), 256'(0));

    // unmasked input, no bubbles
    st = {192'd0, 64'hFEDCBA9876543210};
    run_op(st, -1, -1, -1, 1'b0, '0, 0, lat, used);
    chk("plain_latency", 256'(lat), 256'(19));
    chk("plain_used", 256'(used), 256'(16));
    chk("plain_xor", 256'(unshare(out_state)), 256'(64'hF7E4D583B2A1096C));
    chk("plain_masked", 256'(out_state[255:64] != '0), 256'(1));
    pop();

    // bubbles at T+3, T+4, T+10
    run_op(st, 3, 4, 10, 1'b0, '0, 0, lat, used);
    chk("bubble_latency", 256'(lat), 256'(22));
    chk("bubble_used", 256'(used), 256'(16));
    chk("bubble_xor", 256'(unshare(out_state)), 256'(64'hF7E4D583B2A1096C));
    pop();

    // backpressure for 20 cycles
    st = rand_state();
    run_op(st, -1, -1, -1, 1'b0, '0, 0, lat, used);
    held = out_state;
    chk("bp_xor", 256'(unshare(out_state)), 256'(layer(unshare(st))));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_stable", out_state, held);
      chk("bp_in_ready", 256'(in_ready), 256'(0));
      chk("bp_out_valid", 256'(out_valid), 256'(1));
    end
    pop();

    // reset at T+8, then a fresh state
    st = rand_state();
    run_op(st, -1, -1, -1, 1'b0, '0, 8, lat, used);
    chk("abort_step", 256'(lat), 256'(8));
    st2 = rand_state();
    run_op(st2, -1, -1, -1, 1'b0, '0, 0, lat, used);
    chk("after_abort_latency", 256'(lat), 256'(19));
    chk("after_abort_xor", 256'(unshare(out_state)), 256'(layer(unshare(st2))));
    pop();

    // in_valid held with another state during FEED
    st = rand_state();
    st2 = rand_state();
    run_op(st, -1, -1, -1, 1'b1, st2, 0, lat, used);
    chk("hold_latency", 256'(lat), 256'(19));
    chk("hold_xor", 256'(unshare(out_state)), 256'(layer(unshare(st))));
    pop();

    // random shares and random fresh
    for (int n = 0; n < 1000; n++) begin
      st = rand_state();
      run_op(st, -1, -1, -1, 1'b0, '0, 0, lat, used);
      chk("rand_latency", 256'(lat), 256'(19));
      chk("rand_xor", 256'(unshare(out_state)), 256'(layer(unshare(st))));
      pop();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
